// File: rtl/alarm_button_pio.sv
// Avalon-MM input PIO for the alarm-clock buttons: two-flop synchroniser,
// per-bit debounce, rising-edge capture with write-1-to-clear, and a maskable irq.
module alarm_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clear_bits;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;

  // A bit only moves to its new level once the counter has seen DEBOUNCE_CYCLES mismatches in a row
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < WIDTH; i++) begin
      if ((s2[i] != stable[i]) && (cnt[i] == CNT_MAX)) begin
        stable_next[i] = s2[i];
      end else begin
        stable_next[i] = stable[i];
      end
    end
  end

  assign rise = stable_next & ~stable;

  always_comb begin
    if (wr_en && (address == 2'd3)) begin
      clear_bits = writedata[WIDTH-1:0];
    end else begin
      clear_bits = {WIDTH{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= {WIDTH{1'b0}};
      s2     <= {WIDTH{1'b0}};
      stable <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= {CW{1'b0}};
      end
    end else begin
      s1     <= in_port;
      s2     <= s1;
      stable <= stable_next;
      for (int i = 0; i < WIDTH; i++) begin
        if ((s2[i] == stable[i]) || (cnt[i] == CNT_MAX)) begin
          cnt[i] <= {CW{1'b0}};
        end else begin
          cnt[i] <= cnt[i] + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // A new rising edge outranks a software clear landing in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= {WIDTH{1'b0}};
      irq_mask     <= {WIDTH{1'b0}};
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | rise;
      if (wr_en && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end else begin
        irq_mask <= irq_mask;
      end
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd1:    readdata = 32'd0;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = 32'd0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_alarm_button_pio.sv
// Self-checking bench for alarm_button_pio: directed scenarios plus randomized
// traffic compared against a sliding-window behavioural model.
module tb_alarm_button_pio;
  localparam int W = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Model: hist[k] is in_port as sampled k+1 edges ago
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_stable, m_ec, m_mask;

  alarm_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k <= D; k++) hist[k] = '0;
    m_stable = '0;
    m_ec     = '0;
    m_mask   = '0;
  endtask

  // A level is accepted once the last D synchronised samples all disagree with it
  task automatic model_step();
    logic [W-1:0] flip;
    logic [W-1:0] nst;
    for (int b = 0; b < W; b++) begin
      flip[b] = 1'b1;
      for (int k = 1; k <= D; k++) if (hist[k][b] == m_stable[b]) flip[b] = 1'b0;
    end
    nst = m_stable ^ flip;
    if (chipselect && !write_n) begin
      if (address == 2'd2) m_mask = writedata[W-1:0];
      if (address == 2'd3) m_ec = m_ec & ~writedata[W-1:0];
    end
    m_ec = m_ec | (nst & ~m_stable);
    m_stable = nst;
    for (int k = D; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = in_port;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    exp_rd = {28'd0, m_stable};
      2'd2:    exp_rd = {28'd0, m_mask};
      2'd3:    exp_rd = {28'd0, m_ec};
      default: exp_rd = 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = '0; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = 32'd0;
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      checks++;
      if (readdata !== 32'd0) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_press_latency();
    in_port = 4'b0001;
    for (int n = 1; n <= 7; n++) begin
      tick();
      rd(2'd0);
      checks++;
      if (readdata !== ((n >= 6) ? 32'd1 : 32'd0)) begin
        errors++; $display("FAIL press_stable edge=%0d got=%h exp=%h", n, readdata, (n >= 6) ? 32'd1 : 32'd0);
      end
      rd(2'd3);
      checks++;
      if (readdata !== ((n >= 6) ? 32'd1 : 32'd0)) begin
        errors++; $display("FAIL press_capture edge=%0d got=%h exp=%h", n, readdata, (n >= 6) ? 32'd1 : 32'd0);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked edge=%0d got=%b exp=0", n, irq); end
    end
  endtask

  task automatic test_mask_and_clear();
    wr(2'd2, 32'h0000_0001);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq got=%b exp=1", irq); end
    rd(2'd2);
    checks++;
    if (readdata !== 32'd1) begin errors++; $display("FAIL mask_read got=%h exp=%h", readdata, 32'd1); end
    wr(2'd3, 32'hFFFF_FFF1);
    rd(2'd3);
    checks++;
    if (readdata !== 32'd0) begin errors++; $display("FAIL clear_capture got=%h exp=%h", readdata, 32'd0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got=%b exp=0", irq); end
    rd(2'd0);
    checks++;
    if (readdata !== 32'd1) begin errors++; $display("FAIL clear_keeps_stable got=%h exp=%h", readdata, 32'd1); end
  endtask

  task automatic test_glitch();
    int bad = 0;
    in_port = 4'b0011;
    repeat (3) tick();
    in_port = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      rd(2'd0);
      if (readdata !== 32'd1) bad++;
      rd(2'd3);
      if (readdata !== 32'd0) bad++;
      if (irq !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL glitch_ignored bad_samples=%0d exp=0", bad); end
  endtask

  task automatic test_set_wins();
    in_port = 4'b0101;
    repeat (5) tick();
    rd(2'd3);
    checks++;
    if (readdata !== 32'd0) begin errors++; $display("FAIL setwins_pre got=%h exp=%h", readdata, 32'd0); end
    wr(2'd3, 32'h0000_0004);
    rd(2'd3);
    checks++;
    if (readdata !== 32'd4) begin errors++; $display("FAIL setwins_capture got=%h exp=%h", readdata, 32'd4); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL setwins_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid();
    in_port = 4'b1000;
    repeat (2) tick();
    reset_n = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      checks++;
      if (readdata !== 32'd0) begin
        errors++; $display("FAIL midreset_read addr=%0d got=%h exp=%h", a, readdata, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      rd(2'd3);
      checks++;
      if (readdata !== ((n >= 6) ? 32'd8 : 32'd0)) begin
        errors++; $display("FAIL midreset_recapture edge=%0d got=%h exp=%h", n, readdata, (n >= 6) ? 32'd8 : 32'd0);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      int r;
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 9);
      end else begin
        hold--;
      end
      r = $urandom_range(0, 11);
      if (r < 2) begin
        wr(2'd2, $urandom);
      end else if (r < 4) begin
        wr(2'd3, $urandom);
      end else if (r == 4) begin
        address = 2'($urandom_range(0, 1)); writedata = $urandom;
        chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
      end else if (r == 5) begin
        address = 2'($urandom_range(2, 3)); writedata = $urandom;
        chipselect = 1'b0; write_n = 1'b0;
        tick();
        write_n = 1'b1;
      end else begin
        tick();
      end
      rd(2'($urandom_range(0, 3)));
      checks++;
      if (readdata !== exp_rd(address)) begin
        errors++; $display("FAIL random_read cyc=%0d addr=%0d got=%h exp=%h", c, address, readdata, exp_rd(address));
      end
      checks++;
      if (irq !== |(m_ec & m_mask)) begin
        errors++; $display("FAIL random_irq cyc=%0d got=%b exp=%b", c, irq, |(m_ec & m_mask));
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_mask_and_clear();
    test_glitch();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end

endmodule
